mem_arbiter: RTL

- Shares one multi-cycle unified memory port between the instruction-fetch port and the data port of mips_core.
- Converts each core-side request into a held req/ack transaction on the memory side and returns per-port stall signals.
- Sits between mips_core and a single shared memory, replacing separate inst_rom and data_ram stall paths.
- Round-robin arbitration when both ports request; a timeout guard prevents a hung memory from freezing the core.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_arb2.sv | 18 +
 rtl/mem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states, grant
// identities and the width of the ack-timeout counter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    MA_IDLE   = 3'd0,
    MA_I_ACC  = 3'd1,
    MA_D_ACC  = 3'd2,
    MA_I_DONE = 3'd3,
    MA_D_DONE = 3'd4
  } ma_state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

  // TIMEOUT_CYCLES must fit in this many bits.
  localparam int MA_TMO_CNT_W = 16;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, and on a tie the
// port that was not granted last time wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  grant_t last,
  output logic   gnt0,
  output logic   gnt1
);

  always_comb begin
    gnt0 = req0 & (~req1 | (last == GNT_DATA));
    gnt1 = req1 & (~req0 | (last == GNT_INST));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle req/ack memory port between the instruction-fetch and
// data ports of the core, returning a per-port stall and aborting hung accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_stall,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ack,
  output logic                  err,
  output logic                  busy
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [MA_TMO_CNT_W-1:0] TMO_LIMIT =
    TMO_EN ? MA_TMO_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  ma_state_t               state, next_state;
  grant_t                  last_grant;
  logic [MA_TMO_CNT_W-1:0] tmo_cnt;
  logic                    gnt_i, gnt_d;
  logic                    in_acc, ack_hit, tmo_hit;

  rr_arb2 u_rr_arb2 (
    .req0 (i_req),
    .req1 (d_req),
    .last (last_grant),
    .gnt0 (gnt_i),
    .gnt1 (gnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MA_IDLE;
    else     state <= next_state;
  end

  // An ack in the same cycle as the timeout wins, so the abort needs ~m_ack.
  always_comb begin
    in_acc     = (state == MA_I_ACC) || (state == MA_D_ACC);
    ack_hit    = in_acc & m_ack;
    tmo_hit    = in_acc & ~m_ack & TMO_EN & (tmo_cnt == TMO_LIMIT);
    next_state = state;
    case (state)
      MA_IDLE: begin
        if (gnt_d)      next_state = MA_D_ACC;
        else if (gnt_i) next_state = MA_I_ACC;
      end
      MA_I_ACC:  if (ack_hit || tmo_hit) next_state = MA_I_DONE;
      MA_D_ACC:  if (ack_hit || tmo_hit) next_state = MA_D_DONE;
      MA_I_DONE: next_state = MA_IDLE;
      MA_D_DONE: next_state = MA_IDLE;
      default:   next_state = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_INST;
      tmo_cnt    <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        MA_IDLE: begin
          if (gnt_d) begin
            m_req      <= 1'b1;
            m_we       <= d_we;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            last_grant <= GNT_DATA;
            tmo_cnt    <= '0;
          end else if (gnt_i) begin
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= '0;
            last_grant <= GNT_INST;
            tmo_cnt    <= '0;
          end
        end
        // Read results land in the port's register even if the requester
        // has already walked away; writes never touch d_rdata.
        MA_I_ACC, MA_D_ACC: begin
          if (ack_hit) begin
            m_req <= 1'b0;
            if (state == MA_I_ACC) i_rdata <= m_rdata;
            else if (!m_we)        d_rdata <= m_rdata;
          end else if (tmo_hit) begin
            m_req <= 1'b0;
            err   <= 1'b1;
            if (state == MA_I_ACC) i_rdata <= '0;
            else if (!m_we)        d_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + MA_TMO_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign i_stall = i_req & (state != MA_I_DONE);
  assign d_stall = d_req & (state != MA_D_DONE);
  assign busy    = (state != MA_IDLE);

endmodule
